sobel_gradient_products: RTL and testbench

Pipelined gradient stage directly downstream of the 3×3 window generator in the Harris corner path. Each valid 3×3 pixel window goes through Sobel X/Y kernels to produce Ix and Iy. The stage then forms the three structure-tensor products Ix², Iy² and Ix·Iy, which feed the window-sum / Harris response stage. It also tracks column/row position of each output so downstream stages can identify image borders and frame end.

---
 rtl/sobel_gradient_products.sv | 174 +++++++++++++++++
 tb/tb_sobel_gradient_products.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_gradient_products.sv
// Three-stage Sobel Ix/Iy gradient and structure-tensor product stage with column/row/frame tagging.
// Optional macro SOBEL_BORDER_ZERO_EN: products of border-tagged windows are forced to zero.
module sobel_gradient_products #(
  parameter int DW       = 8,
  parameter int LINE_W   = 512,
  parameter int NUM_ROWS = 510,
  parameter int GW       = DW + 3,
  parameter int PW       = 2 * GW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9*DW-1:0]      in_window,
  input  logic                 in_valid,
  output logic signed [PW-1:0] out_ixx,
  output logic signed [PW-1:0] out_iyy,
  output logic signed [PW-1:0] out_ixy,
  output logic                 out_valid,
  output logic                 out_border,
  output logic [8:0]           out_col,
  output logic                 out_frame_end
);

  localparam int              RW       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [8:0]      COL_LAST = 9'(LINE_W - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(NUM_ROWS - 1);

  // Position counters
  logic [8:0]    r_col;
  logic [RW-1:0] r_row;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_border;
  logic          w_frame_end;

  assign w_col_last  = (r_col == COL_LAST);
  assign w_row_last  = (r_row == ROW_LAST);
  assign w_border    = (r_col == 9'd0) || w_col_last || (r_row == '0) || w_row_last;
  assign w_frame_end = w_col_last && w_row_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // S1: capture window; tags are gated by valid so idle slots carry all-zero tags
  logic [9*DW-1:0] r_s1_win;
  logic            r_s1_valid;
  logic            r_s1_border;
  logic            r_s1_fend;
  logic [8:0]      r_s1_col;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_win    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_fend   <= 1'b0;
      r_s1_col    <= '0;
    end else begin
      r_s1_win    <= in_window;
      r_s1_valid  <= in_valid;
      r_s1_border <= in_valid & w_border;
      r_s1_fend   <= in_valid & w_frame_end;
      r_s1_col    <= in_valid ? r_col : 9'd0;
    end
  end

  // S2: Sobel kernels on zero-extended pixels; +/-4*(2^DW-1) always fits in GW signed bits
  logic [GW-1:0]        w_pix [9];
  logic [GW-1:0]        w_pos_x;
  logic [GW-1:0]        w_neg_x;
  logic [GW-1:0]        w_pos_y;
  logic [GW-1:0]        w_neg_y;
  logic signed [GW-1:0] w_ix;
  logic signed [GW-1:0] w_iy;

  for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
    assign w_pix[gi] = GW'(r_s1_win[gi*DW +: DW]);
  end

  assign w_pos_x = w_pix[2] + (w_pix[5] << 1) + w_pix[8];
  assign w_neg_x = w_pix[0] + (w_pix[3] << 1) + w_pix[6];
  assign w_pos_y = w_pix[6] + (w_pix[7] << 1) + w_pix[8];
  assign w_neg_y = w_pix[0] + (w_pix[1] << 1) + w_pix[2];
  assign w_ix    = $signed(w_pos_x - w_neg_x);
  assign w_iy    = $signed(w_pos_y - w_neg_y);

  logic signed [GW-1:0] r_s2_ix;
  logic signed [GW-1:0] r_s2_iy;
  logic                 r_s2_valid;
  logic                 r_s2_border;
  logic                 r_s2_fend;
  logic [8:0]           r_s2_col;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_ix     <= '0;
      r_s2_iy     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_border <= 1'b0;
      r_s2_fend   <= 1'b0;
      r_s2_col    <= '0;
    end else begin
      r_s2_ix     <= w_ix;
      r_s2_iy     <= w_iy;
      r_s2_valid  <= r_s1_valid;
      r_s2_border <= r_s1_border;
      r_s2_fend   <= r_s1_fend;
      r_s2_col    <= r_s1_col;
    end
  end

  // S3: full-precision signed products
  logic signed [PW-1:0] w_ixx;
  logic signed [PW-1:0] w_iyy;
  logic signed [PW-1:0] w_ixy;
  logic                 w_zero;

  assign w_ixx = PW'(r_s2_ix) * PW'(r_s2_ix);
  assign w_iyy = PW'(r_s2_iy) * PW'(r_s2_iy);
  assign w_ixy = PW'(r_s2_ix) * PW'(r_s2_iy);

`ifdef SOBEL_BORDER_ZERO_EN
  assign w_zero = r_s2_border;
`else
  assign w_zero = 1'b0;
`endif

  logic signed [PW-1:0] r_ixx;
  logic signed [PW-1:0] r_iyy;
  logic signed [PW-1:0] r_ixy;
  logic                 r_valid;
  logic                 r_border;
  logic                 r_fend;
  logic [8:0]           r_out_col;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ixx     <= '0;
      r_iyy     <= '0;
      r_ixy     <= '0;
      r_valid   <= 1'b0;
      r_border  <= 1'b0;
      r_fend    <= 1'b0;
      r_out_col <= '0;
    end else begin
      r_ixx     <= w_zero ? '0 : w_ixx;
      r_iyy     <= w_zero ? '0 : w_iyy;
      r_ixy     <= w_zero ? '0 : w_ixy;
      r_valid   <= r_s2_valid;
      r_border  <= r_s2_border;
      r_fend    <= r_s2_fend;
      r_out_col <= r_s2_col;
    end
  end

  assign out_ixx       = r_ixx;
  assign out_iyy       = r_iyy;
  assign out_ixy       = r_ixy;
  assign out_valid     = r_valid;
  assign out_border    = r_border;
  assign out_frame_end = r_fend;
  assign out_col       = r_out_col;

endmodule

// File: tb/tb_sobel_gradient_products.sv
// Bench for sobel_gradient_products: directed Sobel windows, reset scenarios and a gapped full frame,
// all checked each cycle against a scoreboard built from the kernel equations and window index.
`timescale 1ns/1ps
module tb_sobel_gradient_products;
  localparam int DW       = 8;
  localparam int LINE_W   = 512;
  localparam int NUM_ROWS = 4;
  localparam int GW       = DW + 3;
  localparam int PW       = 2 * GW;

  typedef logic [8:0][DW-1:0] win_t;
  typedef struct {
    int     due;
    longint ixx;
    longint iyy;
    longint ixy;
    bit     border;
    int     col;
    bit     fend;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  win_t                 in_window = '0;
  logic                 in_valid = 1'b0;
  logic signed [PW-1:0] out_ixx;
  logic signed [PW-1:0] out_iyy;
  logic signed [PW-1:0] out_ixy;
  logic                 out_valid;
  logic                 out_border;
  logic [8:0]           out_col;
  logic                 out_frame_end;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   k_acc = 0;
  bit   checking = 1'b0;
  int   n_out = 0;
  int   n_fend = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sobel_gradient_products #(.DW(DW), .LINE_W(LINE_W), .NUM_ROWS(NUM_ROWS)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_window    (in_window),
    .in_valid     (in_valid),
    .out_ixx      (out_ixx),
    .out_iyy      (out_iyy),
    .out_ixy      (out_ixy),
    .out_valid    (out_valid),
    .out_border   (out_border),
    .out_col      (out_col),
    .out_frame_end(out_frame_end)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: window index since reset gives position; kernels computed with plain integers
  exp_t m_e;
  int   m_ix, m_iy, m_row;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      sb.delete();
      k_acc = 0;
    end else if (in_valid) begin
      m_ix = (int'(in_window[2]) + 2*int'(in_window[5]) + int'(in_window[8]))
           - (int'(in_window[0]) + 2*int'(in_window[3]) + int'(in_window[6]));
      m_iy = (int'(in_window[6]) + 2*int'(in_window[7]) + int'(in_window[8]))
           - (int'(in_window[0]) + 2*int'(in_window[1]) + int'(in_window[2]));
      m_e.col    = k_acc % LINE_W;
      m_row      = (k_acc / LINE_W) % NUM_ROWS;
      m_e.border = (m_e.col == 0) || (m_e.col == LINE_W-1) || (m_row == 0) || (m_row == NUM_ROWS-1);
      m_e.fend   = (m_e.col == LINE_W-1) && (m_row == NUM_ROWS-1);
      m_e.ixx    = longint'(m_ix * m_ix);
      m_e.iyy    = longint'(m_iy * m_iy);
      m_e.ixy    = longint'(m_ix * m_iy);
`ifdef SOBEL_BORDER_ZERO_EN
      if (m_e.border) begin
        m_e.ixx = 0;
        m_e.iyy = 0;
        m_e.ixy = 0;
      end
`endif
      m_e.due = cyc + 2;
      k_acc++;
      sb.push_back(m_e);
    end
  end

  // Compare every cycle: either the scheduled window or an idle, all-zero tag set
  exp_t c_e;
  initial forever begin
    @(negedge clk);
    if (checking) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        c_e = sb.pop_front();
        chk("out_valid", longint'(out_valid), 1);
        chk("ixx", longint'(out_ixx), c_e.ixx);
        chk("iyy", longint'(out_iyy), c_e.iyy);
        chk("ixy", longint'(out_ixy), c_e.ixy);
        chk("border", longint'(out_border), longint'(c_e.border));
        chk("col", longint'(out_col), longint'(c_e.col));
        chk("frame_end", longint'(out_frame_end), longint'(c_e.fend));
        $display("out col=%0d border=%0b fend=%0b ixx=%0d iyy=%0d ixy=%0d",
                 out_col, out_border, out_frame_end, out_ixx, out_iyy, out_ixy);
        n_out++;
        if (out_frame_end) n_fend++;
      end else begin
        chk("idle_valid", longint'(out_valid), 0);
        chk("idle_border", longint'(out_border), 0);
        chk("idle_col", longint'(out_col), 0);
        chk("idle_fend", longint'(out_frame_end), 0);
      end
    end
  end

  task automatic drive(input win_t w, input logic v, input logic r);
    @(negedge clk);
    in_window = w;
    in_valid  = v;
    reset     = r;
  endtask

  // Wait (bounded) for the next output and pin it against hand-computed literals
  task automatic wait_lit(input string nm, input longint ixx, input longint iyy,
                          input longint ixy, input int col);
    int   t = 0;
    win_t z = '0;
    while (!out_valid && t < 8) begin
      drive(z, 1'b0, 1'b0);
      t++;
    end
    chk({nm, "_seen"}, longint'(out_valid), 1);
    chk({nm, "_ixx"}, longint'(out_ixx), ixx);
    chk({nm, "_iyy"}, longint'(out_iyy), iyy);
    chk({nm, "_ixy"}, longint'(out_ixy), ixy);
    chk({nm, "_col"}, longint'(out_col), longint'(col));
    $display("directed %s: col=%0d ixx=%0d iyy=%0d ixy=%0d", nm, out_col, out_ixx, out_iyy, out_ixy);
  endtask

  win_t idle_w, flat_w, vedge_w, diag1_w, diag2_w, rnd_w;
  int   base_out, base_fend, sent;

  initial begin
    idle_w  = '0;
    vedge_w = '0;
    diag1_w = '0;
    diag2_w = '0;
    for (int p = 0; p < 9; p++) begin
      flat_w[p]  = 8'd100;
      vedge_w[p] = ((p % 3) == 0) ? 8'd0 : 8'd255;
    end
    diag1_w[0] = 8'd255;
    diag2_w[2] = 8'd255;

    repeat (3) @(negedge clk);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_ixx", longint'(out_ixx), 0);
    chk("rst_iyy", longint'(out_iyy), 0);
    chk("rst_ixy", longint'(out_ixy), 0);
    chk("rst_border", longint'(out_border), 0);
    chk("rst_col", longint'(out_col), 0);
    chk("rst_fend", longint'(out_frame_end), 0);
    reset    = 1'b0;
    checking = 1'b1;

    // Flat window at col 0, then fill to row 1 col 1 for interior directed windows
    drive(flat_w, 1'b1, 1'b0);
    wait_lit("flat", 0, 0, 0, 0);
    for (int i = 0; i < LINE_W; i++) drive(flat_w, 1'b1, 1'b0);
    repeat (5) drive(idle_w, 1'b0, 1'b0);

    drive(vedge_w, 1'b1, 1'b0);
    wait_lit("vedge", 1040400, 0, 0, 1);
    drive(diag1_w, 1'b1, 1'b0);
    wait_lit("diag_tl", 65025, 65025, 65025, 2);
    drive(diag2_w, 1'b1, 1'b0);
    wait_lit("diag_tr", 65025, 65025, -65025, 3);
    repeat (3) drive(idle_w, 1'b0, 1'b0);

    // One-cycle reset with two windows in flight
    base_out = n_out;
    drive(vedge_w, 1'b1, 1'b0);
    drive(diag1_w, 1'b1, 1'b0);
    drive(idle_w, 1'b0, 1'b1);
    repeat (5) drive(idle_w, 1'b0, 1'b0);
    chk("inflight_flushed", longint'(n_out - base_out), 0);
    drive(flat_w, 1'b1, 1'b0);
    wait_lit("after_reset", 0, 0, 0, 0);
    repeat (3) drive(idle_w, 1'b0, 1'b0);

    // Reset concurrent with a valid window: window dropped, counters stay at 0
    base_out = n_out;
    drive(vedge_w, 1'b1, 1'b1);
    repeat (5) drive(idle_w, 1'b0, 1'b0);
    chk("reset_valid_dropped", longint'(n_out - base_out), 0);
    drive(flat_w, 1'b1, 1'b0);
    wait_lit("reset_valid_next", 0, 0, 0, 0);
    repeat (3) drive(idle_w, 1'b0, 1'b0);

    // Full frame of random windows with random valid gaps
    drive(idle_w, 1'b0, 1'b1);
    base_out  = n_out;
    base_fend = n_fend;
    sent      = 0;
    rnd_w     = '0;
    while (sent < LINE_W * NUM_ROWS) begin
      if ($urandom_range(0, 2) != 0) begin
        for (int p = 0; p < 9; p++) rnd_w[p] = 8'($urandom_range(0, 255));
        drive(rnd_w, 1'b1, 1'b0);
        sent++;
      end else begin
        drive(rnd_w, 1'b0, 1'b0);
      end
    end
    repeat (6) drive(idle_w, 1'b0, 1'b0);
    chk("stream_out_count", longint'(n_out - base_out), longint'(LINE_W * NUM_ROWS));
    chk("stream_frame_end_count", longint'(n_fend - base_fend), 1);
    chk("scoreboard_drained", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
